parking_occupancy_counter: RTL and testbench

Tracks the number of cars inside a single-lane parking lot from two beam-break sensors at the gate and presents the occupancy as two BCD digits. It is the stage directly upstream of the 7-segment hex decoders on the DE1-SoC: `count_tens` and `count_ones` drive two decoder instances unchanged. It also drives the lot-full and lot-empty indicators.

---
 rtl/parking_pkg.sv | 32 +++
 rtl/bcd_updown_counter.sv | 80 ++++++++
 rtl/parking_occupancy_counter.sv | 146 ++++++++++++++
 tb/tb_parking_occupancy_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking occupancy counter.
//   gate_state_t : gate FSM states (IDLE, entry path EN1..EN3, exit path
//                  EX1..EX3, WAIT00 recovery state)
//   MAX_CAPACITY : largest occupancy two BCD digits can show
//   bcd_digit_t  : one BCD digit, 0..9
//   cap_tens/cap_ones : split a capacity constant into BCD digits
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EN1    = 3'd1,
    EN2    = 3'd2,
    EN3    = 3'd3,
    EX1    = 3'd4,
    EX2    = 3'd5,
    EX3    = 3'd6,
    WAIT00 = 3'd7
  } gate_state_t;

  localparam int MAX_CAPACITY = 99;

  typedef logic [3:0] bcd_digit_t;

  function automatic bcd_digit_t cap_tens(input int cap);
    return bcd_digit_t'(cap / 10);
  endfunction

  function automatic bcd_digit_t cap_ones(input int cap);
    return bcd_digit_t'(cap % 10);
  endfunction

endpackage

// File: rtl/bcd_updown_counter.sv
// Two-digit saturating BCD up/down counter.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   inc, dec           : single-cycle count requests (never both high)
//   tens, ones         : registered BCD digits of the count
//   inc_accepted       : registered, high for the cycle after an accepted inc
//   dec_accepted       : registered, high for the cycle after an accepted dec
// Parameter CAPACITY: upper saturation limit (1..99).
module bcd_updown_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       inc_accepted,
  output logic       dec_accepted
);

  localparam bcd_digit_t CAP_TENS = cap_tens(CAPACITY);
  localparam bcd_digit_t CAP_ONES = cap_ones(CAPACITY);

  bcd_digit_t tens_q, tens_d;
  bcd_digit_t ones_q, ones_d;
  logic       inc_acc_q, dec_acc_q;
  logic       at_max, at_zero;
  logic       inc_ok, dec_ok;

  assign at_max  = (tens_q == CAP_TENS) && (ones_q == CAP_ONES);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Saturation: a request at the limit is dropped and produces no flag.
  assign inc_ok = inc && !at_max;
  assign dec_ok = dec && !inc && !at_zero;

  // Digit-wise BCD carry/borrow; the count never leaves 00..CAPACITY.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc_ok) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec_ok) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      inc_acc_q <= 1'b0;
      dec_acc_q <= 1'b0;
    end else begin
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      inc_acc_q <= inc_ok;
      dec_acc_q <= dec_ok;
    end
  end

  assign tens         = tens_q;
  assign ones         = ones_q;
  assign inc_accepted = inc_acc_q;
  assign dec_accepted = dec_acc_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy tracker for a single-lane gate with two beam sensors
// (a = outer, b = inner). A gate FSM recognises complete entry
// (a,b = 10,11,01,00) and exit (01,11,10,00) sequences and drives a two-digit
// saturating BCD counter whose digits feed 7-segment decoders directly.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   sensor_a, sensor_b      : beam inputs, 1 = blocked
//   count_tens, count_ones  : BCD occupancy digits
//   full, empty             : occupancy == CAPACITY / occupancy == 0
//   enter_pulse, exit_pulse : one-cycle pulse per counted entry / exit
//   dbg_state               : current gate FSM state (gate_state_t encoding)
// Build option: define PARKING_INPUT_SYNC_EN to pass both sensors through a
// 2-flop synchronizer (adds two cycles of latency); otherwise the sensors
// must already be synchronous to clk.
//
// Handshake: there is no valid/ready; each enter/exit pulse is the only
// qualifier, valid for exactly the one cycle it is high, and the digits
// shown in that same cycle already include the counted event.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic       full,
  output logic       empty,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic [2:0] dbg_state
);

  if (CAPACITY < 1 || CAPACITY > MAX_CAPACITY) begin : g_bad_capacity
    $error("parking_occupancy_counter: CAPACITY must be 1..99");
  end

  localparam bcd_digit_t CAP_TENS = cap_tens(CAPACITY);
  localparam bcd_digit_t CAP_ONES = cap_ones(CAPACITY);

  logic [1:0] s;

`ifdef PARKING_INPUT_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {sensor_a, sensor_b};
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = {sensor_a, sensor_b};
`endif

  gate_state_t state_q, state_d;

  // Any pattern that cannot continue the current path parks the FSM in
  // WAIT00 until the gate clears, so a half-seen car never counts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: case (s)
        2'b10:   state_d = EN1;
        2'b01:   state_d = EX1;
        2'b11:   state_d = WAIT00;
        default: state_d = IDLE;
      endcase
      EN1: case (s)
        2'b11:   state_d = EN2;
        2'b00:   state_d = IDLE;
        2'b01:   state_d = WAIT00;
        default: state_d = EN1;
      endcase
      EN2: case (s)
        2'b01:   state_d = EN3;
        2'b10:   state_d = EN1;
        2'b00:   state_d = WAIT00;
        default: state_d = EN2;
      endcase
      EN3: case (s)
        2'b00:   state_d = IDLE;
        2'b11:   state_d = EN2;
        2'b10:   state_d = WAIT00;
        default: state_d = EN3;
      endcase
      EX1: case (s)
        2'b11:   state_d = EX2;
        2'b00:   state_d = IDLE;
        2'b10:   state_d = WAIT00;
        default: state_d = EX1;
      endcase
      EX2: case (s)
        2'b10:   state_d = EX3;
        2'b01:   state_d = EX1;
        2'b00:   state_d = WAIT00;
        default: state_d = EX2;
      endcase
      EX3: case (s)
        2'b00:   state_d = IDLE;
        2'b11:   state_d = EX2;
        2'b01:   state_d = WAIT00;
        default: state_d = EX3;
      endcase
      WAIT00: begin
        if (s == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Events are decoded from the same edge that returns the FSM to IDLE so
  // the digits and pulse update together with that transition.
  logic entry_evt, exit_evt;
  assign entry_evt = (state_q == EN3) && (s == 2'b00);
  assign exit_evt  = (state_q == EX3) && (s == 2'b00);

  bcd_updown_counter #(.CAPACITY(CAPACITY)) u_counter (
    .clk          (clk),
    .reset        (reset),
    .inc          (entry_evt),
    .dec          (exit_evt),
    .tens         (count_tens),
    .ones         (count_ones),
    .inc_accepted (enter_pulse),
    .dec_accepted (exit_pulse)
  );

  assign full      = (count_tens == CAP_TENS) && (count_ones == CAP_ONES);
  assign empty     = (count_tens == 4'd0) && (count_ones == 4'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
module tb_parking_occupancy_counter;
  import parking_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: default capacity (25), index 1: capacity 3
  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic       sa0 = 1'b0, sb0 = 1'b0, sa1 = 1'b0, sb1 = 1'b0;
  logic [3:0] tens0, ones0, tens1, ones1;
  logic       full0, empty0, enp0, exp0, full1, empty1, enp1, exp1;
  logic [2:0] st0, st1;

  parking_occupancy_counter dut (
    .clk(clk), .reset(rst0), .sensor_a(sa0), .sensor_b(sb0),
    .count_tens(tens0), .count_ones(ones0), .full(full0), .empty(empty0),
    .enter_pulse(enp0), .exit_pulse(exp0), .dbg_state(st0)
  );

  parking_occupancy_counter #(.CAPACITY(3)) dut3 (
    .clk(clk), .reset(rst1), .sensor_a(sa1), .sensor_b(sb1),
    .count_tens(tens1), .count_ones(ones1), .full(full1), .empty(empty1),
    .enter_pulse(enp1), .exit_pulse(exp1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  // record = {enter, exit, tens[3:0], ones[3:0], full, empty}
  localparam int W = 12;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int total = 0;
  int bad   = 0;
  int occ[2];
  int cap[2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic en, input logic ex, input int o, input int c);
    return {en, ex, 4'(o / 10), 4'(o % 10), (o == c), (o == 0)};
  endfunction

  // model: update occupancy, queue a pulse only if the event is accepted
  task automatic model_event(input int which, input bit is_enter);
    if (is_enter && occ[which] < cap[which]) begin
      occ[which]++;
      if (which == 0) exp_q0.push_back(rec(1'b1, 1'b0, occ[0], cap[0]));
      else            exp_q1.push_back(rec(1'b1, 1'b0, occ[1], cap[1]));
    end else if (!is_enter && occ[which] > 0) begin
      occ[which]--;
      if (which == 0) exp_q0.push_back(rec(1'b0, 1'b1, occ[0], cap[0]));
      else            exp_q1.push_back(rec(1'b0, 1'b1, occ[1], cap[1]));
    end
  endtask

  // monitors: compare every pulse against the head of its queue
  always @(negedge clk) begin
    if (!rst0 && (enp0 || exp0)) begin
      if (exp_q0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse0 got=%0h want=none", {enp0, exp0, tens0, ones0, full0, empty0});
      end else begin
        chk("pulse0", 32'({enp0, exp0, tens0, ones0, full0, empty0}), 32'(exp_q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && (enp1 || exp1)) begin
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse1 got=%0h want=none", {enp1, exp1, tens1, ones1, full1, empty1});
      end else begin
        chk("pulse1", 32'({enp1, exp1, tens1, ones1, full1, empty1}), 32'(exp_q1.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic put(input int which, input logic [1:0] s);
    @(posedge clk); #1;
    if (which == 0) {sa0, sb0} = s;
    else            {sa1, sb1} = s;
  endtask

  task automatic settle(input int which);
    repeat (4) put(which, 2'b00);
  endtask

  task automatic do_entry(input int which);
    model_event(which, 1'b1);
    put(which, 2'b10); put(which, 2'b11); put(which, 2'b01); put(which, 2'b00);
    settle(which);
  endtask

  task automatic do_exit(input int which);
    model_event(which, 1'b0);
    put(which, 2'b01); put(which, 2'b11); put(which, 2'b10); put(which, 2'b00);
    settle(which);
  endtask

  task automatic chk_count(input string name, input int which, input int want_occ);
    @(negedge clk);
    if (which == 0)
      chk(name, 32'({tens0, ones0, full0, empty0}), 32'({4'(want_occ / 10), 4'(want_occ % 10), want_occ == cap[0], want_occ == 0}));
    else
      chk(name, 32'({tens1, ones1, full1, empty1}), 32'({4'(want_occ / 10), 4'(want_occ % 10), want_occ == cap[1], want_occ == 0}));
  endtask

  task automatic chk_state(input string name, input int which, input gate_state_t want);
    @(negedge clk);
    if (which == 0) chk(name, 32'(st0), 32'(want));
    else            chk(name, 32'(st1), 32'(want));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cap[0] = 25; cap[1] = 3;
    occ[0] = 0;  occ[1] = 0;
    repeat (3) @(posedge clk);
    #1; rst0 = 1'b0; rst1 = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset_digits", 32'({tens0, ones0}), 32'h00);
    chk("reset_flags", 32'({full0, empty0, enp0, exp0}), 32'b0100);
    chk("reset_state", 32'(st0), 32'(IDLE));

    // single entry
    do_entry(0);
    chk_count("one_entry", 0, 1);

    // up to 09, then BCD carry to 10, then borrow back to 09
    for (int i = 0; i < 8; i++) do_entry(0);
    chk_count("count_09", 0, 9);
    do_entry(0);
    chk_count("carry_10", 0, 10);
    do_exit(0);
    chk_count("borrow_09", 0, 9);

    // drain to zero, then an exit at zero must be ignored
    for (int i = 0; i < 9; i++) do_exit(0);
    chk_count("drained", 0, 0);
    do_exit(0);
    chk_count("exit_at_zero", 0, 0);

    // reversal and illegal jump leave the count alone
    do_entry(0);
    put(0, 2'b10); put(0, 2'b11); put(0, 2'b10); put(0, 2'b00);
    settle(0);
    chk_count("reversal_count", 0, 1);
    chk_state("reversal_state", 0, IDLE);
    put(0, 2'b10); put(0, 2'b01); put(0, 2'b00);
    settle(0);
    chk_count("illegal_count", 0, 1);
    chk_state("illegal_state", 0, IDLE);

    // reset in EN2 with s=11 held through release
    put(0, 2'b10); put(0, 2'b11);
    repeat (2) @(posedge clk);
    #1; rst0 = 1'b1;
    occ[0] = 0;
    repeat (2) @(posedge clk);
    #1; rst0 = 1'b0;
    repeat (4) @(posedge clk);
    chk_state("reset_mid_state", 0, WAIT00);
    chk_count("reset_mid_count", 0, 0);
    settle(0);
    chk_state("wait00_exit", 0, IDLE);
    do_entry(0);
    chk_count("after_reset_entry", 0, 1);

    // capacity 3: saturation at full
    for (int i = 0; i < 3; i++) do_entry(1);
    chk_count("cap3_full", 1, 3);
    do_entry(1);
    chk_count("cap3_saturate", 1, 3);
    do_exit(1);
    chk_count("cap3_after_exit", 1, 2);

    // every queued pulse must have been seen
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("missing_pulses0", 32'(exp_q0.size()), 32'd0);
    chk("missing_pulses1", 32'(exp_q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
